uart_host_if: RTL and testbench

Bus-side host controller for the UART core: owns the divisor, break and ack controls, and buffers traffic in both directions. Sits between the minion peripheral bus and the UART's parallel interface. Drives `transmit`/`tx_byte` from a TX FIFO and drains `received`/`rx_byte` into an RX FIFO with `recv_ack` handshaking. Exposes a four-register map and a level interrupt.

---
 rtl/uart_host_if.sv | 188 ++++++++++++++++++
 tb/tb_uart_host_if.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_if.sv
// Bus-side host controller for the UART core: register map, TX/RX FIFOs, TX launch engine, RX capture, level irq.
// Optional feature: define UART_HOST_LOOPBACK_EN to implement CTRL[3] (TX FIFO drains straight into the RX FIFO).
`timescale 1ns/1ps
module uart_host_if #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [15:0] DEFAULT_BAUD = 16'd1302
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_en,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq,
  output logic        uart_transmit,
  output logic [7:0]  uart_tx_byte,
  input  logic        uart_is_transmitting,
  input  logic        uart_received,
  input  logic [7:0]  uart_rx_byte,
  input  logic        uart_recv_error,
  output logic [15:0] uart_baud,
  output logic        uart_brk,
  output logic        uart_recv_ack
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE} txState_e;
  txState_e txState_q, txState_d;

  logic [7:0]    txMem_q [FIFO_DEPTH];
  logic [7:0]    rxMem_q [FIFO_DEPTH];
  logic [AW-1:0] txWrPtr_q, txRdPtr_q, rxWrPtr_q, rxRdPtr_q;
  logic [CW-1:0] txCount_q, txCount_d, rxCount_q, rxCount_d;
  logic [15:0]   baud_q;
  logic [3:0]    ctrl_q, ctrl_d;
  logic          txOvf_q, txOvf_d, rxOvf_q, rxOvf_d, rxErr_q, rxErr_d;
  logic [31:0]   rdata_q, rdata_d, status;
  logic          irq_q, recvAck_q;
  logic [7:0]    txByte_q;

  logic busRd, busWr, txFull, txEmpty, rxFull, rxEmpty, loopbackOn;
  logic launch, capture, loopMove, txPush, txPop, txDrop;
  logic rxPop, rxPushReq, rxPush, rxDrop, rxErrSet;
  logic [7:0] txHead, rxPushData;
  logic [2:0] stickyClr;
  logic unused_wdata;

`ifdef UART_HOST_LOOPBACK_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
  assign loopbackOn = ctrl_q[3];
`else
  localparam logic [3:0] CTRL_MASK = 4'h7;
  assign loopbackOn = 1'b0;
`endif

  assign busRd   = bus_en & ~bus_we;
  assign busWr   = bus_en & bus_we;
  assign txFull  = (txCount_q == FULL_COUNT);
  assign txEmpty = (txCount_q == '0);
  assign rxFull  = (rxCount_q == FULL_COUNT);
  assign rxEmpty = (rxCount_q == '0);
  assign txHead  = txMem_q[txRdPtr_q];

  // A full FIFO still accepts a push when it is popped in the same cycle.
  assign launch     = (txState_q == TX_IDLE) & ~txEmpty & ~uart_is_transmitting & ~loopbackOn;
  assign capture    = ~recvAck_q & uart_received;
  assign loopMove   = loopbackOn & ~txEmpty & ~capture;
  assign txPop      = launch | loopMove;
  assign txPush     = busWr & (bus_addr == 2'd0) & (~txFull | txPop);
  assign txDrop     = busWr & (bus_addr == 2'd0) & txFull & ~txPop;
  assign rxPop      = busRd & (bus_addr == 2'd0) & ~rxEmpty;
  assign rxPushReq  = capture | loopMove;
  assign rxPushData = capture ? uart_rx_byte : txHead;
  assign rxPush     = rxPushReq & (~rxFull | rxPop);
  assign rxDrop     = rxPushReq & rxFull & ~rxPop;
  assign rxErrSet   = ~recvAck_q & uart_recv_error;

  assign txCount_d = txCount_q + CW'(txPush) - CW'(txPop);
  assign rxCount_d = rxCount_q + CW'(rxPush) - CW'(rxPop);

  // Clearing writes are applied first so a coincident set event wins.
  assign stickyClr = (busWr && bus_addr == 2'd1) ? bus_wdata[7:5] : 3'b000;
  assign rxOvf_d   = (rxOvf_q & ~stickyClr[0]) | rxDrop;
  assign rxErr_d   = (rxErr_q & ~stickyClr[1]) | rxErrSet;
  assign txOvf_d   = (txOvf_q & ~stickyClr[2]) | txDrop;

  assign unused_wdata = ^bus_wdata[31:16];

  always_comb begin
    ctrl_d = ctrl_q;
    if (busWr && bus_addr == 2'd3) ctrl_d = bus_wdata[3:0] & CTRL_MASK;
  end

  always_comb begin
    status        = '0;
    status[0]     = txFull;
    status[1]     = txEmpty;
    status[2]     = rxFull;
    status[3]     = rxEmpty;
    status[4]     = uart_is_transmitting;
    status[5]     = rxOvf_q;
    status[6]     = rxErr_q;
    status[7]     = txOvf_q;
    status[12:8]  = 5'(rxCount_q);
    status[20:16] = 5'(txCount_q);
    rdata_d = rdata_q;
    if (busRd) begin
      case (bus_addr)
        2'd0:    rdata_d = rxEmpty ? 32'd0 : {23'd0, 1'b1, rxMem_q[rxRdPtr_q]};
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = {16'd0, baud_q};
        default: rdata_d = {28'd0, ctrl_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) txState_q <= TX_IDLE;
    else     txState_q <= txState_d;
  end

  always_comb begin
    txState_d = txState_q;
    case (txState_q)
      TX_IDLE:      if (launch)                txState_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (uart_is_transmitting)  txState_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!uart_is_transmitting) txState_d = TX_IDLE;
      default:                                 txState_d = TX_IDLE;
    endcase
  end

  // The launched byte is shown combinationally in the pulse cycle, then held in txByte_q.
  always_comb begin
    uart_transmit = launch;
    uart_tx_byte  = txByte_q;
    if (launch) uart_tx_byte = txHead;
  end

  always_ff @(posedge clk) begin
    if (txPush) txMem_q[txWrPtr_q] <= bus_wdata[7:0];
    if (rxPush) rxMem_q[rxWrPtr_q] <= rxPushData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txWrPtr_q <= '0;
      txRdPtr_q <= '0;
      rxWrPtr_q <= '0;
      rxRdPtr_q <= '0;
      txCount_q <= '0;
      rxCount_q <= '0;
      baud_q    <= DEFAULT_BAUD;
      ctrl_q    <= '0;
      txOvf_q   <= 1'b0;
      rxOvf_q   <= 1'b0;
      rxErr_q   <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      recvAck_q <= 1'b0;
      txByte_q  <= '0;
    end else begin
      if (txPush) txWrPtr_q <= txWrPtr_q + AW'(1);
      if (txPop)  txRdPtr_q <= txRdPtr_q + AW'(1);
      if (rxPush) rxWrPtr_q <= rxWrPtr_q + AW'(1);
      if (rxPop)  rxRdPtr_q <= rxRdPtr_q + AW'(1);
      txCount_q <= txCount_d;
      rxCount_q <= rxCount_d;
      if (busWr && bus_addr == 2'd2) baud_q <= bus_wdata[15:0];
      ctrl_q    <= ctrl_d;
      txOvf_q   <= txOvf_d;
      rxOvf_q   <= rxOvf_d;
      rxErr_q   <= rxErr_d;
      rdata_q   <= rdata_d;
      irq_q     <= (ctrl_q[1] & ~rxEmpty) | (ctrl_q[2] & txEmpty);
      recvAck_q <= ~recvAck_q & (uart_received | uart_recv_error);
      if (launch) txByte_q <= txHead;
    end
  end

  assign bus_rdata     = rdata_q;
  assign irq           = irq_q;
  assign uart_baud     = baud_q;
  assign uart_brk      = ctrl_q[0];
  assign uart_recv_ack = recvAck_q;
endmodule

// File: tb/tb_uart_host_if.sv
// Self-checking bench for uart_host_if: queue-based behavioural model compared every cycle, plus directed literal checks.
// Honours UART_HOST_LOOPBACK_EN the same way the design does.
`timescale 1ns/1ps
module tb_uart_host_if;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_en = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        irq;
  logic        uart_transmit;
  logic [7:0]  uart_tx_byte;
  logic        uart_is_transmitting = 1'b0;
  logic        uart_received = 1'b0;
  logic [7:0]  uart_rx_byte = 8'd0;
  logic        uart_recv_error = 1'b0;
  logic [15:0] uart_baud;
  logic        uart_brk;
  logic        uart_recv_ack;

  uart_host_if #(.FIFO_DEPTH(DEPTH), .DEFAULT_BAUD(16'd1302)) dut (
    .clk(clk), .rst(rst), .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting), .uart_received(uart_received),
    .uart_rx_byte(uart_rx_byte), .uart_recv_error(uart_recv_error),
    .uart_baud(uart_baud), .uart_brk(uart_brk), .uart_recv_ack(uart_recv_ack)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mTx[$];
  logic [7:0]  mRx[$];
  logic        mTxOvf, mRxOvf, mRxErr, mIrq, mAck, mArmed, mSawBusy;
  logic [15:0] mBaud;
  logic [3:0]  mCtrl;
  logic [31:0] mRdata;
  logic [7:0]  mTxByte;

  function automatic logic lbOn();
`ifdef UART_HOST_LOOPBACK_EN
    return mCtrl[3];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] ctrlMask();
`ifdef UART_HOST_LOOPBACK_EN
    return 4'hF;
`else
    return 4'h7;
`endif
  endfunction

  function automatic logic expLaunch();
    return mArmed && (mTx.size() != 0) && !uart_is_transmitting && !lbOn();
  endfunction

  task automatic modelReset();
    mTx.delete();
    mRx.delete();
    mTxOvf = 0; mRxOvf = 0; mRxErr = 0; mIrq = 0; mAck = 0;
    mArmed = 1; mSawBusy = 0;
    mBaud = 16'd1302; mCtrl = 4'd0; mRdata = 32'd0; mTxByte = 8'd0;
  endtask

  task automatic rxModelPush(input logic [7:0] b);
    if (mRx.size() < DEPTH) mRx.push_back(b);
    else mRxOvf = 1;
  endtask

  task automatic modelStep();
    logic [31:0] st;
    logic launchNow, capture, loopNow, ackNext, irqNext;
    logic [7:0] b;
    st = 32'd0;
    st[0] = (mTx.size() == DEPTH);
    st[1] = (mTx.size() == 0);
    st[2] = (mRx.size() == DEPTH);
    st[3] = (mRx.size() == 0);
    st[4] = uart_is_transmitting;
    st[5] = mRxOvf;
    st[6] = mRxErr;
    st[7] = mTxOvf;
    st[12:8] = 5'(mRx.size());
    st[20:16] = 5'(mTx.size());
    launchNow = expLaunch();
    capture = !mAck && uart_received;
    loopNow = lbOn() && (mTx.size() != 0) && !capture;
    irqNext = (mCtrl[1] && mRx.size() != 0) || (mCtrl[2] && mTx.size() == 0);
    ackNext = !mAck && (uart_received || uart_recv_error);
    b = 8'd0;
    if (bus_en && !bus_we) begin
      case (bus_addr)
        2'd0: if (mRx.size() != 0) mRdata = {23'd0, 1'b1, mRx.pop_front()}; else mRdata = 32'd0;
        2'd1: mRdata = st;
        2'd2: mRdata = {16'd0, mBaud};
        default: mRdata = {28'd0, mCtrl};
      endcase
    end
    if (launchNow || loopNow) b = mTx.pop_front();
    if (launchNow) begin
      mTxByte = b; mArmed = 0; mSawBusy = 0;
    end else if (!mArmed) begin
      if (!mSawBusy) mSawBusy = uart_is_transmitting;
      else if (!uart_is_transmitting) mArmed = 1;
    end
    if (bus_en && bus_we) begin
      case (bus_addr)
        2'd0: if (mTx.size() < DEPTH) mTx.push_back(bus_wdata[7:0]); else mTxOvf = 1;
        2'd1: begin
          if (bus_wdata[5]) mRxOvf = 0;
          if (bus_wdata[6]) mRxErr = 0;
          if (bus_wdata[7]) mTxOvf = 0;
        end
        2'd2: mBaud = bus_wdata[15:0];
        default: mCtrl = bus_wdata[3:0] & ctrlMask();
      endcase
    end
    if (capture) rxModelPush(uart_rx_byte);
    else if (loopNow) rxModelPush(b);
    if (!mAck && uart_recv_error) mRxErr = 1;
    mAck = ackNext;
    mIrq = irqNext;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else modelStep();
  end

  // Single compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic expTx;
    logic [7:0] expByte;
    expTx = expLaunch();
    expByte = mTxByte;
    if (expTx) expByte = mTx[0];
    checkOutput("bus_rdata", bus_rdata, mRdata);
    checkOutput("irq", {31'd0, irq}, {31'd0, mIrq});
    checkOutput("uart_transmit", {31'd0, uart_transmit}, {31'd0, expTx});
    checkOutput("uart_tx_byte", {24'd0, uart_tx_byte}, {24'd0, expByte});
    checkOutput("uart_recv_ack", {31'd0, uart_recv_ack}, {31'd0, mAck});
    checkOutput("uart_baud", {16'd0, uart_baud}, {16'd0, mBaud});
    checkOutput("uart_brk", {31'd0, uart_brk}, {31'd0, mCtrl[0]});
  end

  // ---------------- UART model and bus driving ----------------
  logic [7:0] txLog[$];
  int uDelay = 0;
  int uBusyLeft = 0;
  int busyLen = 40;
  int ackCount = 0;

  task automatic tick();
    logic txPulse, ackSeen;
    logic [7:0] txb;
    @(negedge clk);
    txPulse = uart_transmit;
    txb = uart_tx_byte;
    ackSeen = uart_recv_ack;
    @(posedge clk);
    #1;
    if (txPulse) begin
      txLog.push_back(txb);
      uDelay = $urandom_range(1, 3);
    end else if (uDelay != 0) begin
      uDelay--;
      if (uDelay == 0) begin
        uart_is_transmitting = 1'b1;
        uBusyLeft = busyLen;
      end
    end else if (uBusyLeft != 0) begin
      uBusyLeft--;
      if (uBusyLeft == 0) uart_is_transmitting = 1'b0;
    end
    if (ackSeen) begin
      uart_received = 1'b0;
      uart_recv_error = 1'b0;
      ackCount++;
    end
    bus_en = 1'b0;
    bus_we = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    tick();
    d = bus_rdata;
  endtask

  task automatic rxDeliver(input logic [7:0] b, input logic rcv, input logic err);
    uart_rx_byte = b;
    uart_received = rcv;
    uart_recv_error = err;
    for (int k = 0; k < 20 && (uart_received || uart_recv_error); k++) tick();
    tests++;
    if (uart_received || uart_recv_error) begin
      failures++;
      $display("[TB] FAIL rxAckTimeout: input still pending, expected ack within 20 cycles");
      uart_received = 1'b0;
      uart_recv_error = 1'b0;
    end
    tick();
  endtask

  task automatic waitTxDone(input int want);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (txLog.size() == want && uDelay == 0 && uBusyLeft == 0) break;
      tick();
    end
    tests++;
    if (k == 2000) begin
      failures++;
      $display("[TB] FAIL txDoneTimeout: got %0d launches, expected %0d", txLog.size(), want);
    end
    repeat (3) tick();
  endtask

  task automatic applyStimulus();
    if ($urandom_range(0, 1) == 1) begin
      bus_en = 1'b1;
      bus_we = $urandom_range(0, 1) == 1;
      bus_addr = 2'($urandom_range(0, 3));
      bus_wdata = $urandom();
    end
    if (!uart_received && !uart_recv_error && $urandom_range(0, 5) == 0) begin
      uart_rx_byte = 8'($urandom());
      uart_received = $urandom_range(0, 3) != 0;
      uart_recv_error = $urandom_range(0, 4) == 0;
    end
    tick();
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    checkOutput("resetBaudPin", {16'd0, uart_baud}, 32'd1302);
    checkOutput("resetRdata", bus_rdata, 32'd0);
    checkOutput("resetIrq", {31'd0, irq}, 32'd0);
    busRead(2'd2, rd);
    checkOutput("resetBaudReg", rd, 32'h0000_0516);
    busRead(2'd1, rd);
    checkOutput("resetStatus", rd, 32'h0000_000A);

    // Two TX bytes through a slow UART
    busyLen = 40;
    txLog.delete();
    busWrite(2'd0, 32'h41);
    busWrite(2'd0, 32'h42);
    waitTxDone(2);
    checkOutput("txCount", txLog.size(), 32'd2);
    if (txLog.size() == 2) begin
      checkOutput("txByte0", {24'd0, txLog[0]}, 32'h41);
      checkOutput("txByte1", {24'd0, txLog[1]}, 32'h42);
    end
    busRead(2'd1, rd);
    checkOutput("txDrainedStatus", rd, 32'h0000_000A);

    // Single RX byte
    ackCount = 0;
    rxDeliver(8'h5A, 1'b1, 1'b0);
    repeat (2) tick();
    checkOutput("rxAckCount", ackCount, 32'd1);
    busRead(2'd1, rd);
    checkOutput("rxOneStatus", rd, 32'h0000_0102);
    busRead(2'd0, rd);
    checkOutput("rxData", rd, 32'h0000_015A);
    busRead(2'd0, rd);
    checkOutput("rxEmptyRead", rd, 32'h0000_0000);

    // Overflow the RX FIFO
    for (int i = 0; i < 17; i++) rxDeliver(8'(8'h80 + i), 1'b1, 1'b0);
    busRead(2'd1, rd);
    checkOutput("rxOvfStatus", rd, 32'h0000_1026);
    for (int i = 0; i < 16; i++) begin
      busRead(2'd0, rd);
      checkOutput($sformatf("rxOrder%0d", i), rd, 32'h180 + i);
    end
    busWrite(2'd1, 32'h20);
    busRead(2'd1, rd);
    checkOutput("rxOvfCleared", rd, 32'h0000_000A);

    // Framing error and RX interrupt
    ackCount = 0;
    rxDeliver(8'h00, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("errAckCount", ackCount, 32'd1);
    busRead(2'd1, rd);
    checkOutput("rxErrStatus", rd, 32'h0000_004A);
    busWrite(2'd1, 32'h40);
    busWrite(2'd3, 32'h2);
    rxDeliver(8'h77, 1'b1, 1'b0);
    tick();
    checkOutput("irqHigh", {31'd0, irq}, 32'd1);
    busRead(2'd0, rd);
    checkOutput("irqData", rd, 32'h0000_0177);
    checkOutput("irqHeldAfterRead", {31'd0, irq}, 32'd1);
    tick();
    checkOutput("irqDropped", {31'd0, irq}, 32'd0);
    busWrite(2'd3, 32'h0);

`ifdef UART_HOST_LOOPBACK_EN
    // Loopback path
    txLog.delete();
    busWrite(2'd3, 32'h8);
    busWrite(2'd0, 32'h33);
    repeat (3) tick();
    busRead(2'd0, rd);
    checkOutput("loopData", rd, 32'h0000_0133);
    checkOutput("loopNoLaunch", txLog.size(), 32'd0);
    busWrite(2'd3, 32'h0);
`endif

    // Randomized traffic with one asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      if (uDelay == 0 && uBusyLeft == 0) busyLen = $urandom_range(3, 12);
      if (c == 1500) begin
        #2 rst = 1'b1;
        uart_received = 1'b0;
        uart_recv_error = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
      end
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
